// File: rtl/morse_pkg.sv
// Shared encodings and timing constants for the Morse letter sequencer.
// MORSE_WORD_GAP_EN adds the word-gap state and its timing constant.
package morse_pkg;

  localparam int SYM_MAX = 5;
  localparam int LEN_W   = 3;
  localparam int BITS_W  = 5;

  // Silicon defaults: 0.5 s letter gap and 1 s word gap at 50 MHz.
  localparam int          DEF_T_BIT  = 26;
  localparam int unsigned DEF_T_GAP  = 32'h017D_7840;
  localparam int unsigned DEF_T_WORD = 32'h02FA_F080;

  // Scaled-down values that keep simulations short.
  localparam int          SIM_T_BIT  = 4;
  localparam int unsigned SIM_T_GAP  = 4;
  localparam int unsigned SIM_T_WORD = 10;

`ifdef MORSE_WORD_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_EMIT  = 3'd3,
    S_WGAP  = 3'd4
  } morse_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRESS = 3'd1,
    S_GAP   = 3'd2,
    S_EMIT  = 3'd3
  } morse_state_e;
`endif

endpackage

// File: rtl/morse_gap_timer.sv
// Saturating idle-time counter with letter-gap (and, under MORSE_WORD_GAP_EN,
// word-gap) terminal flags.
module morse_gap_timer
  import morse_pkg::*;
#(
  parameter int          T_BIT  = DEF_T_BIT,
  parameter int unsigned T_GAP  = DEF_T_GAP
`ifdef MORSE_WORD_GAP_EN
  ,
  parameter int unsigned T_WORD = DEF_T_WORD
`endif
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic gap_hit
`ifdef MORSE_WORD_GAP_EN
  ,
  output logic word_hit
`endif
);

  localparam logic [T_BIT-1:0] GAP_LAST  = T_BIT'(T_GAP - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [T_BIT-1:0] WORD_LAST = T_BIT'(T_WORD - 1);
  localparam logic [T_BIT-1:0] SAT_LAST  = WORD_LAST;
`else
  localparam logic [T_BIT-1:0] SAT_LAST  = GAP_LAST;
`endif

  logic [T_BIT-1:0] cnt_q;

  // Holds at the last terminal value so a long idle never wraps into a false gap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != SAT_LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign gap_hit  = (cnt_q == GAP_LAST);
`ifdef MORSE_WORD_GAP_EN
  assign word_hit = (cnt_q == WORD_LAST);
`endif

endmodule

// File: rtl/morse_symbol_ctrl.sv
// Collects dot/dash elements into letters and hands them downstream with valid/ready.
// MORSE_WORD_GAP_EN adds a word-space symbol (sym_len=0) after a long idle.
module morse_symbol_ctrl
  import morse_pkg::*;
#(
  parameter int          T_BIT  = DEF_T_BIT,
  parameter int unsigned T_GAP  = DEF_T_GAP
`ifdef MORSE_WORD_GAP_EN
  ,
  parameter int unsigned T_WORD = DEF_T_WORD
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bt_start,
  input  logic              bt_done,
  input  logic              length,
  input  logic              sym_ready,
  output logic              sym_valid,
  output logic [LEN_W-1:0]  sym_len,
  output logic [BITS_W-1:0] sym_bits,
  output logic              err
);

  // Handshake: a symbol transfers on a cycle where sym_valid & sym_ready are
  // both high; sym_valid, sym_len and sym_bits hold steady until that cycle.

  morse_state_e      state_q, state_d;
  logic [BITS_W-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              tmr_clr, tmr_en, gap_hit;
  logic              start_ok;
`ifdef MORSE_WORD_GAP_EN
  logic              word_hit;
`endif

  // A release in the same cycle as a press wins; the press is ignored.
  assign start_ok = bt_start && !bt_done;

  morse_gap_timer #(
    .T_BIT (T_BIT),
    .T_GAP (T_GAP)
`ifdef MORSE_WORD_GAP_EN
    ,
    .T_WORD(T_WORD)
`endif
  ) u_gap_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .gap_hit (gap_hit)
`ifdef MORSE_WORD_GAP_EN
    ,
    .word_hit(word_hit)
`endif
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PRESS;
          tmr_clr = 1'b1;
        end
      end
      S_PRESS: begin
        if (bt_done) begin
          tmr_clr = 1'b1;
          state_d = S_GAP;
          if (cnt_q == LEN_W'(SYM_MAX)) begin
            err_d = 1'b1;
          end else begin
            buf_d = buf_q | (BITS_W'(length) << cnt_q);
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        tmr_en = 1'b1;
        if (start_ok) begin
          state_d = S_PRESS;
          tmr_clr = 1'b1;
        end else if (gap_hit) begin
          state_d = S_EMIT;
          valid_d = 1'b1;
        end
      end
      S_EMIT: begin
`ifdef MORSE_WORD_GAP_EN
        // Keep timing from the letter's release so the word gap is measured end to end.
        tmr_en = 1'b1;
`endif
        if (bt_done) err_d = 1'b1;
        if (valid_q && sym_ready) begin
          valid_d = 1'b0;
          buf_d   = '0;
          cnt_d   = '0;
`ifdef MORSE_WORD_GAP_EN
          state_d = (cnt_q != '0) ? S_WGAP : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef MORSE_WORD_GAP_EN
      S_WGAP: begin
        tmr_en = 1'b1;
        if (start_ok) begin
          state_d = S_PRESS;
          tmr_clr = 1'b1;
        end else if (word_hit) begin
          state_d = S_EMIT;
          valid_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // The element buffer doubles as the output register; it is frozen while in EMIT.
  assign sym_valid = valid_q;
  assign sym_len   = cnt_q;
  assign sym_bits  = buf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_morse_symbol_ctrl.sv
// Directed bench for morse_symbol_ctrl with scaled timing (T_GAP=4, T_WORD=10).
// Build with MORSE_WORD_GAP_EN defined to cover the word-space symbol.
module tb_morse_symbol_ctrl;
  import morse_pkg::*;

  logic              clk;
  logic              n_rst;
  logic              bt_start;
  logic              bt_done;
  logic              length;
  logic              sym_ready;
  logic              sym_valid;
  logic [LEN_W-1:0]  sym_len;
  logic [BITS_W-1:0] sym_bits;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int err_exp     = 0;
  logic [7:0] exp_q[$];

  morse_symbol_ctrl #(
    .T_BIT (SIM_T_BIT),
    .T_GAP (SIM_T_GAP)
`ifdef MORSE_WORD_GAP_EN
    ,
    .T_WORD(SIM_T_WORD)
`endif
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bt_start (bt_start),
    .bt_done  (bt_done),
    .length   (length),
    .sym_ready(sym_ready),
    .sym_valid(sym_valid),
    .sym_len  (sym_len),
    .sym_bits (sym_bits),
    .err      (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // One press/release; returns one step after the edge that sampled bt_done.
  task automatic press(input logic dash);
    bt_start = 1'b1;
    cyc();
    bt_start = 1'b0;
    cyc();
    bt_done = 1'b1;
    length  = dash;
    cyc();
    bt_done = 1'b0;
    length  = 1'b0;
  endtask

  task automatic push_letter(input logic [2:0] len, input logic [4:0] bits);
    exp_q.push_back({len, bits});
  endtask

  task automatic push_space();
`ifdef MORSE_WORD_GAP_EN
    exp_q.push_back(8'h00);
`endif
  endtask

  // scoreboard: pops one expectation per accepted symbol
  always @(negedge clk) begin
    if (n_rst && sym_valid && sym_ready) begin
      check("letter_pending", 8'(exp_q.size() != 0), 8'd1);
      if (exp_q.size() != 0) check("letter", {sym_len, sym_bits}, exp_q.pop_front());
    end
    if (n_rst && err) err_seen++;
  end

  initial begin
    n_rst     = 1'b0;
    bt_start  = 1'b0;
    bt_done   = 1'b0;
    length    = 1'b0;
    sym_ready = 1'b1;
    cycles(2);
    check("rst_valid", 8'(sym_valid), 8'd0);
    check("rst_len",   8'(sym_len),   8'd0);
    check("rst_bits",  8'(sym_bits),  8'd0);
    check("rst_err",   8'(err),       8'd0);
    n_rst = 1'b1;
    cycles(2);

    // dot, dash, dot then letter gap
    push_letter(3'd3, 5'b00010);
    push_space();
    press(1'b0); cyc();
    press(1'b1); cyc();
    press(1'b0);
    cycles(3);
    check("t1_early", 8'(sym_valid), 8'd0);
    cyc();
    check("t1_valid", 8'(sym_valid), 8'd1);
    check("t1_data",  {sym_len, sym_bits}, {3'd3, 5'b00010});
    cyc();
    check("t1_one_cycle", 8'(sym_valid), 8'd0);
    cycles(14);

    // six dashes: the sixth overflows
    push_letter(3'd5, 5'b11111);
    push_space();
    for (int i = 0; i < 6; i++) begin
      press(1'b1);
      if (i < 5) cyc();
    end
    err_exp++;
    check("t2_err", 8'(err), 8'd1);
    cyc();
    check("t2_err_one", 8'(err), 8'd0);
    cycles(16);

    // back-pressure with a press+release arriving during EMIT
    sym_ready = 1'b0;
    push_letter(3'd2, 5'b00001);
    push_space();
    press(1'b1); cyc();
    press(1'b0);
    cycles(4);
    check("t3_valid", 8'(sym_valid), 8'd1);
    bt_start = 1'b1;
    bt_done  = 1'b1;
    cyc();
    bt_start = 1'b0;
    bt_done  = 1'b0;
    err_exp++;
    check("t3_err", 8'(err), 8'd1);
    check("t3_hold_valid", 8'(sym_valid), 8'd1);
    check("t3_hold_data", {sym_len, sym_bits}, {3'd2, 5'b00001});
    cyc();
    check("t3_err_one", 8'(err), 8'd0);
    cycles(3);
    check("t3_still_valid", 8'(sym_valid), 8'd1);
    check("t3_stable", {sym_len, sym_bits}, {3'd2, 5'b00001});
    sym_ready = 1'b1;
    cyc();
    check("t3_accepted", 8'(sym_valid), 8'd0);
    cycles(14);

    // reset in the middle of a letter
    press(1'b0); cyc();
    press(1'b1); cyc();
    check("t4_partial", {sym_len, sym_bits}, {3'd2, 5'b00010});
    n_rst = 1'b0;
    #1;
    check("t4_rst_valid", 8'(sym_valid), 8'd0);
    check("t4_rst_data", {sym_len, sym_bits}, 8'd0);
    check("t4_rst_err", 8'(err), 8'd0);
    cycles(2);
    n_rst = 1'b1;
    cycles(14);
    check("t4_no_letter", 8'(sym_valid), 8'd0);

    // three idle cycles between elements keep one letter
    push_letter(3'd2, 5'b00010);
    push_space();
    press(1'b0);
    cycles(3);
    press(1'b1);
    cycles(16);

    // four idle cycles close the letter
    push_letter(3'd1, 5'b00000);
    push_letter(3'd1, 5'b00001);
    push_space();
    press(1'b0);
    cycles(4);
    check("t5_split", 8'(sym_valid), 8'd1);
    cycles(3);
    press(1'b1);
    cycles(16);

    // single dot followed by a long idle
    push_letter(3'd1, 5'b00000);
    push_space();
    press(1'b0);
    cycles(4);
    check("t6_letter", {sym_valid, sym_len, sym_bits[3:0]}, {1'b1, 3'd1, 4'd0});
    cycles(6);
`ifdef MORSE_WORD_GAP_EN
    check("t6_space", {sym_valid, sym_len, sym_bits[3:0]}, {1'b1, 3'd0, 4'd0});
`else
    check("t6_no_space", 8'(sym_valid), 8'd0);
`endif
    cyc();
    check("t6_after", 8'(sym_valid), 8'd0);
    cycles(20);

    check("queue_drained", 8'(exp_q.size()), 8'd0);
    check("err_count", 8'(err_seen), 8'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
